// File: rtl/spart_prog_loader.sv
// SPART program loader: parses a framed image from the receive byte stream,
// writes it into instruction memory and hands the start PC to fetch.
module spart_prog_loader #(
    parameter int         ADDR_W  = 10,
    parameter logic [7:0] MAGIC   = 8'hA5,
    parameter int         TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              switch_program,
    output logic [31:0]       SPART_pc,
    output logic              load_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_PC, S_CNT, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [31:0]       pc;
    logic [15:0]       rem;
    logic [23:0]       word;
    logic [7:0]        sum;
    logic [1:0]        bcnt;
    logic [ADDR_W-1:0] widx;
    logic [31:0]       tmr;
    logic [15:0]       cnt_n;
    logic              tmo;
    logic              in_frame;

    assign cnt_n    = {rem[7:0], rx_data};
    assign in_frame = (state == S_PC) || (state == S_CNT) ||
                      (state == S_DATA) || (state == S_CSUM);
    assign tmo      = !rx_valid && (tmr == 32'(TIMEOUT - 1));

    assign switch_program = (state == S_DONE);
    assign load_err       = (state == S_ERR);
    assign busy           = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state: frame parser, an idle timeout aborts any open frame
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == MAGIC) state_n = S_PC;
            end
            S_PC: begin
                if (tmo) state_n = S_ERR;
                else if (rx_valid && bcnt == 2'd3) state_n = S_CNT;
            end
            S_CNT: begin
                if (tmo) begin
                    state_n = S_ERR;
                end else if (rx_valid && bcnt == 2'd1) begin
                    if (32'(cnt_n) > 32'(2 ** ADDR_W)) state_n = S_ERR;
                    else if (cnt_n == 16'd0)           state_n = S_CSUM;
                    else                               state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tmo) state_n = S_ERR;
                else if (rx_valid && bcnt == 2'd3 && rem == 16'd1)
                    state_n = S_CSUM;
            end
            S_CSUM: begin
                if (tmo) state_n = S_ERR;
                else if (rx_valid)
                    state_n = (rx_data == sum) ? S_DONE : S_ERR;
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: field shifting, checksum, word writes and hold control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= '0;
            rem        <= '0;
            word       <= '0;
            sum        <= '0;
            bcnt       <= '0;
            widx       <= '0;
            tmr        <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            SPART_pc   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (rx_valid || !in_frame) tmr <= '0;
            else                       tmr <= tmr + 32'd1;
            if (rx_valid) begin
                unique case (state)
                    S_IDLE: begin
                        if (rx_data == MAGIC) begin
                            sum      <= '0;
                            bcnt     <= '0;
                            widx     <= '0;
                            cpu_hold <= 1'b1;
                        end
                    end
                    S_PC: begin
                        pc   <= {pc[23:0], rx_data};
                        sum  <= sum + rx_data;
                        bcnt <= bcnt + 2'd1;
                    end
                    S_CNT: begin
                        rem  <= cnt_n;
                        sum  <= sum + rx_data;
                        bcnt <= (bcnt == 2'd1) ? 2'd0 : bcnt + 2'd1;
                    end
                    S_DATA: begin
                        word <= {word[15:0], rx_data};
                        sum  <= sum + rx_data;
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {word, rx_data};
                            imem_waddr <= pc[ADDR_W-1:0] + widx;
                            widx       <= widx + 1'b1;
                            rem        <= rem - 16'd1;
                        end
                    end
                    S_CSUM: begin
                        if (rx_data == sum) begin
                            cpu_hold <= 1'b0;
                            SPART_pc <= pc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_prog_loader.sv
// Self-checking bench for spart_prog_loader: table of frames plus
// hand-written reset, noise and timeout sequences, with a write scoreboard.
module tb_spart_prog_loader;

    localparam int ADDR_W = 10;
    localparam int TMO    = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              switch_program;
    logic [31:0]       SPART_pc;
    logic              load_err;
    logic              busy;

    spart_prog_loader #(
        .ADDR_W (ADDR_W),
        .MAGIC  (8'hA5),
        .TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .cpu_hold      (cpu_hold),
        .switch_program(switch_program),
        .SPART_pc      (SPART_pc),
        .load_err      (load_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          bad;
        bit          exp_sw;
        bit          exp_err;
        bit          exp_hold;
    } vec_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          passed = 0;
    int          sw_cnt = 0;
    int          err_cnt = 0;
    int          extra_wr = 0;
    logic [31:0] sw_pc = '0;
    wr_t         got_e;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: scoreboard writes and count pulses
    always @(negedge clk) begin
        if (rst) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    extra_wr++;
                end else begin
                    got_e = exp_q.pop_front();
                    check("waddr", 64'(imem_waddr), 64'(got_e.addr));
                    check("wdata", 64'(imem_wdata), 64'(got_e.data));
                end
            end
            if (switch_program) begin
                sw_cnt++;
                sw_pc = SPART_pc;
                check("hold_at_switch", 64'(cpu_hold), 64'(0));
                check("no_collision", 64'(imem_we), 64'(0));
            end
            if (load_err) err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic logic [31:0] wgen(vec_t v, int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return v.w1 + 32'(i) * 32'h01010103;
    endfunction

    task automatic send_frame(input vec_t v);
        logic [7:0]  s;
        logic [7:0]  b;
        logic [31:0] w;
        logic [15:0] c;
        wr_t         e;
        s = 8'h00;
        c = v.cnt[15:0];
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            b = 8'(v.pc >> (24 - 8 * i));
            s = s + b;
            send_byte(b);
        end
        s = s + c[15:8] + c[7:0];
        send_byte(c[15:8]);
        send_byte(c[7:0]);
        if (v.cnt > 1024) return;
        for (int k = 0; k < v.cnt; k++) begin
            w = wgen(v, k);
            e.addr = ADDR_W'((v.pc + 32'(k)) & 32'h3FF);
            e.data = w;
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) begin
                b = 8'(w >> (24 - 8 * i));
                s = s + b;
                send_byte(b);
            end
        end
        send_byte(v.bad ? s + 8'd1 : s);
    endtask

    vec_t vecs[7];

    task automatic run_vec(input int n);
        int sw0;
        int er0;
        sw0 = sw_cnt;
        er0 = err_cnt;
        send_frame(vecs[n]);
        repeat (4) @(negedge clk);
        check($sformatf("v%0d_switch", n), 64'(sw_cnt - sw0),
              64'(vecs[n].exp_sw));
        check($sformatf("v%0d_err", n), 64'(err_cnt - er0),
              64'(vecs[n].exp_err));
        check($sformatf("v%0d_writes_left", n), 64'(exp_q.size()), 64'(0));
        check($sformatf("v%0d_extra_wr", n), 64'(extra_wr), 64'(0));
        check($sformatf("v%0d_hold", n), 64'(cpu_hold),
              64'(vecs[n].exp_hold));
        check($sformatf("v%0d_busy", n), 64'(busy), 64'(0));
        if (vecs[n].exp_sw)
            check($sformatf("v%0d_pc", n), 64'(sw_pc), 64'(vecs[n].pc));
    endtask

    initial begin
        int sw0;
        int er0;
        wr_t e;
        vecs[0] = '{32'h00000010, 2, 32'hDEADBEEF, 32'h12345678, 0, 1, 0, 0};
        vecs[1] = '{32'h00000010, 2, 32'hDEADBEEF, 32'h12345678, 1, 0, 1, 1};
        vecs[2] = '{32'h000003FF, 2, 32'hCAFEF00D, 32'h0BADC0DE, 0, 1, 0, 0};
        vecs[3] = '{32'h12345678, 3, 32'hA5A5A5A5, 32'h00A5FF01, 0, 1, 0, 0};
        vecs[4] = '{32'h00000020, 1025, 32'h0, 32'h0, 0, 0, 1, 1};
        vecs[5] = '{32'h00000080, 0, 32'h0, 32'h0, 0, 1, 0, 0};
        vecs[6] = '{32'h00000200, 1024, 32'h11223344, 32'h55667788, 0, 1, 0, 0};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hold", 64'(cpu_hold), 64'(0));
        check("rst_we", 64'(imem_we), 64'(0));
        check("rst_pc", 64'(SPART_pc), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (3) @(negedge clk);
        check("noise_busy", 64'(busy), 64'(0));
        check("noise_hold", 64'(cpu_hold), 64'(0));
        check("noise_pulses", 64'(sw_cnt + err_cnt + extra_wr), 64'(0));

        for (int n = 0; n < 7; n++) run_vec(n);

        sw0 = sw_cnt;
        er0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h30);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_hold", 64'(cpu_hold), 64'(0));
        check("mid_rst_pc", 64'(SPART_pc), 64'(0));
        check("mid_rst_we", 64'(imem_we), 64'(0));
        check("mid_rst_sw", 64'(switch_program), 64'(0));
        check("mid_rst_err", 64'(load_err), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_no_pulse", 64'(sw_cnt - sw0 + err_cnt - er0),
              64'(0));
        run_vec(0);

        er0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h00); send_byte(8'h02);
        e.addr = 10'h040;
        e.data = 32'h01020304;
        exp_q.push_back(e);
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
        repeat (TMO / 2) @(negedge clk);
        check("tmo_not_early", 64'(err_cnt - er0), 64'(0));
        repeat (TMO / 2 + 5) @(negedge clk);
        check("tmo_err", 64'(err_cnt - er0), 64'(1));
        check("tmo_busy", 64'(busy), 64'(0));
        check("tmo_hold", 64'(cpu_hold), 64'(1));
        check("tmo_writes", 64'(exp_q.size()), 64'(0));
        check("tmo_extra_wr", 64'(extra_wr), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
